// File: rtl/line_mux_pkg.sv
// rtl/line_mux_pkg.sv - shared defaults and width helper for the line rotator mux
package line_mux_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_LINES = 4;
  localparam int DEF_OUT_ROWS  = 3;
  localparam int DEF_LINE_LEN  = 512;

  // ceil(log2(value)), never less than 1 so single-entry ranges still get a bit
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/line_pos_tracker.sv
// rtl/line_pos_tracker.sv - pixel counter, rotation pointer and line-end strobe
// LINE_ROTATOR_SOF_EN adds the sof input that restarts position at pixel 0, ptr 0.
module line_pos_tracker
  import line_mux_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_LEN  = DEF_LINE_LEN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
`ifdef LINE_ROTATOR_SOF_EN
  input  logic                                sof,
`endif
  output logic [clog2_min1(NUM_LINES)-1:0]    rot_ptr,
  output logic [clog2_min1(NUM_LINES)-1:0]    sel_ptr,
  output logic                                wrap
);

  localparam int CNT_W = clog2_min1(LINE_LEN);
  localparam int PTR_W = clog2_min1(NUM_LINES);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LINES - 1);

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] pix_cnt_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic             sof_hit;

`ifdef LINE_ROTATOR_SOF_EN
  assign sof_hit = sof;
`else
  assign sof_hit = 1'b0;
`endif

  // sof beats count as pixel 0 of line 0, so they never end a line
  always_comb begin
    pix_cnt_nxt = pix_cnt;
    ptr_nxt     = rot_ptr;
    sel_ptr     = rot_ptr;
    wrap        = 1'b0;
    if (sof_hit) begin
      sel_ptr     = '0;
      ptr_nxt     = '0;
      pix_cnt_nxt = in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      if (pix_cnt == LAST_PIX) begin
        wrap        = 1'b1;
        pix_cnt_nxt = '0;
        ptr_nxt     = (rot_ptr == LAST_PTR) ? '0 : rot_ptr + PTR_W'(1);
      end else begin
        pix_cnt_nxt = pix_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      rot_ptr <= '0;
    end else begin
      pix_cnt <= pix_cnt_nxt;
      rot_ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/line_rotator_mux.sv
// rtl/line_rotator_mux.sv - registered rotating line-buffer to window-row mux
// LINE_ROTATOR_SOF_EN adds the sof input for frame-aligned pointer restart.
module line_rotator_mux
  import line_mux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int OUT_ROWS  = DEF_OUT_ROWS,
  parameter int LINE_LEN  = DEF_LINE_LEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_LINES*DATA_W-1:0]       in_lines,
  input  logic                              in_valid,
`ifdef LINE_ROTATOR_SOF_EN
  input  logic                              sof,
`endif
  output logic [OUT_ROWS*DATA_W-1:0]        out_rows,
  output logic                              out_valid,
  output logic                              line_done,
  output logic [clog2_min1(NUM_LINES)-1:0]  rot_ptr
);

  localparam int PTR_W = clog2_min1(NUM_LINES);

  logic [PTR_W-1:0]           sel_ptr;
  logic                       wrap;
  logic [OUT_ROWS*DATA_W-1:0] rows_sel;

  line_pos_tracker #(
    .NUM_LINES (NUM_LINES),
    .LINE_LEN  (LINE_LEN)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
`ifdef LINE_ROTATOR_SOF_EN
    .sof      (sof),
`endif
    .rot_ptr  (rot_ptr),
    .sel_ptr  (sel_ptr),
    .wrap     (wrap)
  );

  // sum stays below 2*NUM_LINES, so one conditional subtract is a full modulo
  for (genvar k = 0; k < OUT_ROWS; k++) begin : g_row
    logic [PTR_W:0] idx_sum;
    logic [PTR_W:0] idx;
    assign idx_sum = {1'b0, sel_ptr} + (PTR_W+1)'(k + 1);
    assign idx = (idx_sum >= (PTR_W+1)'(NUM_LINES)) ? idx_sum - (PTR_W+1)'(NUM_LINES) : idx_sum;
    assign rows_sel[k*DATA_W +: DATA_W] = in_lines[int'(idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_rows  <= '0;
      out_valid <= 1'b0;
      line_done <= 1'b0;
    end else begin
      out_valid <= in_valid;
      line_done <= wrap;
      if (in_valid) out_rows <= rows_sel;
    end
  end

endmodule

// File: tb/tb_line_rotator_mux.sv
// tb/tb_line_rotator_mux.sv - randomized model-checked bench for line_rotator_mux
// Instance b exercises non-power-of-two lines; LINE_ROTATOR_SOF_EN enables the sof scenario.
module tb_line_rotator_mux;

  localparam int W  = 8;
  localparam int NA = 4, RA = 3, LA = 512;
  localparam int NB = 5, RB = 5, LB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NA*W-1:0] a_lines = '0;
  logic            a_valid = 1'b0;
  logic [RA*W-1:0] a_rows;
  logic            a_ovalid, a_done;
  logic [1:0]      a_ptr;

  logic [NB*W-1:0] b_lines = '0;
  logic            b_valid = 1'b0;
  logic [RB*W-1:0] b_rows;
  logic            b_ovalid, b_done;
  logic [2:0]      b_ptr;
`ifdef LINE_ROTATOR_SOF_EN
  logic            b_sof = 1'b0;
`endif

  line_rotator_mux #(.DATA_W(W), .NUM_LINES(NA), .OUT_ROWS(RA), .LINE_LEN(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_lines(a_lines), .in_valid(a_valid),
`ifdef LINE_ROTATOR_SOF_EN
    .sof(1'b0),
`endif
    .out_rows(a_rows), .out_valid(a_ovalid), .line_done(a_done), .rot_ptr(a_ptr)
  );

  line_rotator_mux #(.DATA_W(W), .NUM_LINES(NB), .OUT_ROWS(RB), .LINE_LEN(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_lines(b_lines), .in_valid(b_valid),
`ifdef LINE_ROTATOR_SOF_EN
    .sof(b_sof),
`endif
    .out_rows(b_rows), .out_valid(b_ovalid), .line_done(b_done), .rot_ptr(b_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state: valid beats since reset/sof; position and pointer follow arithmetically
  int              a_beats = 0;
  logic [RA*W-1:0] a_exp_rows = '0;
  logic            a_exp_valid = 1'b0, a_exp_done = 1'b0;
  int              b_beats = 0;
  logic [RB*W-1:0] b_exp_rows = '0;
  logic            b_exp_valid = 1'b0, b_exp_done = 1'b0;

  function automatic logic [63:0] sel_model(input logic [63:0] lines, input int ptr,
                                            input int n, input int r);
    logic [63:0] res;
    res = '0;
    for (int k = 0; k < r; k++) res[k*W +: W] = lines[((ptr + 1 + k) % n)*W +: W];
    return res;
  endfunction

  task automatic beat_a(input logic v, input logic [NA*W-1:0] lines);
    logic [63:0] s;
    a_valid = v;
    a_lines = lines;
    a_exp_valid = v;
    a_exp_done = 1'b0;
    if (v) begin
      s = sel_model(64'(lines), (a_beats / LA) % NA, NA, RA);
      a_exp_rows = s[RA*W-1:0];
      a_exp_done = (a_beats % LA) == LA - 1;
      a_beats++;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic beat_b(input logic v, input logic s_in);
    logic [63:0] s;
    b_valid = v;
    b_lines = (NB*W)'({$urandom, $urandom});
`ifdef LINE_ROTATOR_SOF_EN
    b_sof = s_in;
    if (s_in) b_beats = 0;
`endif
    b_exp_valid = v;
    b_exp_done = 1'b0;
    if (v) begin
      s = sel_model(64'(b_lines), (b_beats / LB) % NB, NB, RB);
      b_exp_rows = s[RB*W-1:0];
      b_exp_done = (b_beats % LB) == LB - 1;
      b_beats++;
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
`ifdef LINE_ROTATOR_SOF_EN
    b_sof = 1'b0;
`endif
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_beats = 0; a_exp_rows = '0; a_exp_valid = 1'b0; a_exp_done = 1'b0;
    b_beats = 0; b_exp_rows = '0; b_exp_valid = 1'b0; b_exp_done = 1'b0;
  endtask

  task automatic test_reset;
    a_lines = $urandom;
    apply_reset();
    n_checks++;
    if ({a_rows, a_ovalid, a_done, a_ptr} !== '0) begin
      n_fail++;
      $display("FAIL reset_a got rows=%h v=%b d=%b ptr=%0d exp all zero", a_rows, a_ovalid, a_done, a_ptr);
    end
    n_checks++;
    if ({b_rows, b_ovalid, b_done, b_ptr} !== '0) begin
      n_fail++;
      $display("FAIL reset_b got rows=%h v=%b d=%b ptr=%0d exp all zero", b_rows, b_ovalid, b_done, b_ptr);
    end
  endtask

  task automatic test_first_line;
    beat_a(1'b1, 32'h40302010);
    n_checks++;
    if ({a_rows, a_ovalid, a_ptr} !== {24'h403020, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL first_beat got rows=%h v=%b ptr=%0d exp rows=403020 v=1 ptr=0", a_rows, a_ovalid, a_ptr);
    end
  endtask

  task automatic test_line_wrap;
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 1; i < LA; i++) begin
      beat_a(1'b1, $urandom);
      n_checks++;
      if ({a_rows, a_ovalid, a_done, a_ptr} !== {a_exp_rows, a_exp_valid, a_exp_done, 2'((a_beats / LA) % NA)}) begin
        n_fail++;
        $display("FAIL wrap_beat%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, a_rows, a_ovalid, a_done, a_ptr,
                 a_exp_rows, a_exp_valid, a_exp_done, (a_beats / LA) % NA);
      end
      if (a_done) begin pulses++; pulse_at = i; end
    end
    n_checks++;
    if (pulses !== 1 || pulse_at !== LA - 1) begin
      n_fail++;
      $display("FAIL wrap_pulse got count=%0d at=%0d exp count=1 at=%0d", pulses, pulse_at, LA - 1);
    end
    beat_a(1'b1, 32'h40302010);
    n_checks++;
    if ({a_rows, a_ptr, a_done} !== {24'h104030, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_map got rows=%h ptr=%0d d=%b exp rows=104030 ptr=1 d=0", a_rows, a_ptr, a_done);
    end
  endtask

  task automatic test_pointer_wrap;
    logic [1:0] seq [4];
    apply_reset();
    for (int ln = 0; ln < NA; ln++) begin
      for (int i = 0; i < LA; i++) begin
        beat_a(1'b1, $urandom);
        n_checks++;
        if ({a_rows, a_ovalid, a_done, a_ptr} !== {a_exp_rows, a_exp_valid, a_exp_done, 2'((a_beats / LA) % NA)}) begin
          n_fail++;
          $display("FAIL ptrwrap_l%0d_b%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", ln, i, a_rows, a_ovalid, a_done,
                   a_ptr, a_exp_rows, a_exp_valid, a_exp_done, (a_beats / LA) % NA);
        end
      end
      seq[ln] = a_ptr;
    end
    n_checks++;
    if ({seq[0], seq[1], seq[2], seq[3]} !== {2'd1, 2'd2, 2'd3, 2'd0}) begin
      n_fail++;
      $display("FAIL ptr_seq got %0d,%0d,%0d,%0d exp 1,2,3,0", seq[0], seq[1], seq[2], seq[3]);
    end
    beat_a(1'b1, 32'h40302010);
    n_checks++;
    if (a_rows !== 24'h403020) begin
      n_fail++;
      $display("FAIL ptrwrap_map got rows=%h exp rows=403020", a_rows);
    end
  endtask

  task automatic test_gaps;
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < LA + 5; i++) begin
      beat_a(i < LA - 1 || i == LA + 4, $urandom);
      n_checks++;
      if ({a_rows, a_ovalid, a_done, a_ptr} !== {a_exp_rows, a_exp_valid, a_exp_done, 2'((a_beats / LA) % NA)}) begin
        n_fail++;
        $display("FAIL gap_beat%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, a_rows, a_ovalid, a_done, a_ptr,
                 a_exp_rows, a_exp_valid, a_exp_done, (a_beats / LA) % NA);
      end
      if (a_done) pulses++;
    end
    n_checks++;
    if ({pulses, a_done} !== {32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL gap_done got count=%0d last=%b exp count=1 last=1", pulses, a_done);
    end
  endtask

  task automatic test_random_gaps;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      beat_a($urandom_range(0, 3) != 0, $urandom);
      n_checks++;
      if ({a_rows, a_ovalid, a_done, a_ptr} !== {a_exp_rows, a_exp_valid, a_exp_done, 2'((a_beats / LA) % NA)}) begin
        n_fail++;
        $display("FAIL rnd_beat%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, a_rows, a_ovalid, a_done, a_ptr,
                 a_exp_rows, a_exp_valid, a_exp_done, (a_beats / LA) % NA);
      end
    end
  endtask

  task automatic test_reset_midline;
    apply_reset();
    for (int i = 0; i < 2*LA + 200; i++) beat_a(1'b1, $urandom);
    n_checks++;
    if (a_ptr !== 2'd2) begin
      n_fail++;
      $display("FAIL midline_ptr got %0d exp 2", a_ptr);
    end
    apply_reset();
    n_checks++;
    if ({a_rows, a_ovalid, a_done, a_ptr} !== '0) begin
      n_fail++;
      $display("FAIL midline_reset got rows=%h v=%b d=%b ptr=%0d exp all zero", a_rows, a_ovalid, a_done, a_ptr);
    end
    for (int i = 0; i < LA; i++) begin
      beat_a(1'b1, $urandom);
      n_checks++;
      if ({a_rows, a_ovalid, a_done, a_ptr} !== {a_exp_rows, a_exp_valid, a_exp_done, 2'((a_beats / LA) % NA)}) begin
        n_fail++;
        $display("FAIL after_reset_b%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, a_rows, a_ovalid, a_done, a_ptr,
                 a_exp_rows, a_exp_valid, a_exp_done, (a_beats / LA) % NA);
      end
    end
  endtask

  task automatic test_nonpow2;
    int seen = 0;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      beat_b($urandom_range(0, 3) != 0, 1'b0);
      n_checks++;
      if ({b_rows, b_ovalid, b_done, b_ptr} !== {b_exp_rows, b_exp_valid, b_exp_done, 3'((b_beats / LB) % NB)}) begin
        n_fail++;
        $display("FAIL np2_beat%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, b_rows, b_ovalid, b_done, b_ptr,
                 b_exp_rows, b_exp_valid, b_exp_done, (b_beats / LB) % NB);
      end
      seen |= 1 << b_ptr;
    end
    n_checks++;
    if (seen !== 31) begin
      n_fail++;
      $display("FAIL np2_ptr_cover got mask=%b exp 11111", seen[4:0]);
    end
  endtask

`ifdef LINE_ROTATOR_SOF_EN
  task automatic test_sof;
    apply_reset();
    for (int i = 0; i < 2*LB + 2; i++) beat_b(1'b1, 1'b0);
    beat_b(1'b1, 1'b1);
    n_checks++;
    if ({b_done, b_ptr, b_rows[W-1:0]} !== {1'b0, 3'd0, b_lines[2*W-1:W]}) begin
      n_fail++;
      $display("FAIL sof_valid got d=%b ptr=%0d row0=%h exp d=0 ptr=0 row0=%h", b_done, b_ptr, b_rows[W-1:0],
               b_lines[2*W-1:W]);
    end
    beat_b(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      beat_b($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0);
      n_checks++;
      if ({b_rows, b_ovalid, b_done, b_ptr} !== {b_exp_rows, b_exp_valid, b_exp_done, 3'((b_beats / LB) % NB)}) begin
        n_fail++;
        $display("FAIL sof_beat%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, b_rows, b_ovalid, b_done, b_ptr,
                 b_exp_rows, b_exp_valid, b_exp_done, (b_beats / LB) % NB);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_line();
    test_line_wrap();
    test_pointer_wrap();
    test_gaps();
    test_random_gaps();
    test_reset_midline();
    test_nonpow2();
`ifdef LINE_ROTATOR_SOF_EN
    test_sof();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
